lif_neuron_array: RTL

Parametrised array of N fixed-point leaky integrate-and-fire neurons that advance together on a timestep strobe. Each neuron adds a signed weight when its binary input is set, applies a shift-based leak, fires when it reaches threshold, then sits out a programmable refractory period. A saturating per-neuron spike counter tracks activity. This block replaces the single real-valued neuron in the spiking datapath with a synthesisable, multi-channel core.

---
 rtl/lif_neuron_array_if.sv | 32 +++
 rtl/lif_neuron_array.sv | 110 +++++++++++
 2 files changed

// File: rtl/lif_neuron_array_if.sv
// Bundle of the timestep, input and result signals of lif_neuron_array.
//   step        : timestep strobe, state advances only when set
//   clear       : synchronous soft clear of all neuron state
//   in_spikes   : binary input per neuron (N bits)
//   weights     : signed weight per neuron, neuron i at [i*PW +: PW]
//   spike_out   : per-neuron spike result of the last step
//   spike_valid : one-cycle pulse, spike_out is fresh
//   spike_count : saturating spike count per neuron, neuron i at [i*CNT_W +: CNT_W]
// master drives step/clear/in_spikes/weights; slave (the neuron array) drives the results.
interface lif_neuron_array_if #(
  parameter int N     = 8,
  parameter int PW    = 16,
  parameter int CNT_W = 8
);
  logic               step;
  logic               clear;
  logic [N-1:0]       in_spikes;
  logic [N*PW-1:0]    weights;
  logic [N-1:0]       spike_out;
  logic               spike_valid;
  logic [N*CNT_W-1:0] spike_count;

  modport master (
    output step, clear, in_spikes, weights,
    input  spike_out, spike_valid, spike_count
  );

  modport slave (
    input  step, clear, in_spikes, weights,
    output spike_out, spike_valid, spike_count
  );
endinterface

// File: rtl/lif_neuron_array.sv
// Array of N fixed-point leaky integrate-and-fire neurons advancing together on
// a timestep strobe. Potentials are signed Q(PW-8).8; each step applies a shift
// leak, adds the weight when the input bit is set, saturates, and fires at
// THRESHOLD. After a spike a neuron is held at RESET_VALUE for REFRACT steps.
// Ports:
//   clk     : clock, all state changes on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : lif_neuron_array_if.slave (step, clear, in_spikes, weights in;
//             spike_out, spike_valid, spike_count out)
module lif_neuron_array #(
  parameter int                     N           = 8,
  parameter int                     PW          = 16,
  parameter int                     LEAK_SHIFT  = 3,
  parameter logic signed [PW-1:0]   THRESHOLD   = 16'sh0100,
  parameter logic signed [PW-1:0]   RESET_VALUE = 16'sh0033,
  parameter int                     REFRACT     = 2,
  parameter int                     CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  lif_neuron_array_if.slave bus
);

  // Refractory counter must hold REFRACT; keep at least one bit when disabled.
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  localparam logic signed [PW-1:0] POT_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] POT_MIN = {1'b1, {(PW-1){1'b0}}};

  logic valid_q;

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= 1'b0;
    else          valid_q <= bus.step && !bus.clear;
  end

  assign bus.spike_valid = valid_q;

  for (genvar i = 0; i < N; i++) begin : g_neuron
    logic signed [PW-1:0] pot, pot_nxt, pot_shr, sat, w;
    logic        [RW-1:0] refr, refr_nxt;
    logic     [CNT_W-1:0] cnt, cnt_nxt;
    logic                 spk, spk_nxt;
    logic                 fire;
    logic signed [PW:0]   leak_ext, sum_ext;

    assign w       = bus.weights[i*PW +: PW];
    assign pot_shr = pot >>> LEAK_SHIFT;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
      pot_nxt  = pot;
      refr_nxt = refr;
      cnt_nxt  = cnt;
      spk_nxt  = spk;

      // p - (p >>> k) keeps the sign of p and shrinks its magnitude, so one
      // guard bit is enough to also absorb the weight addition.
      leak_ext = {pot[PW-1], pot} - {pot_shr[PW-1], pot_shr};
      sum_ext  = leak_ext + (bus.in_spikes[i] ? {w[PW-1], w} : '0);

      if (sum_ext[PW] != sum_ext[PW-1]) sat = sum_ext[PW] ? POT_MIN : POT_MAX;
      else                              sat = sum_ext[PW-1:0];

      fire = (refr == '0) && (sat >= THRESHOLD);

      if (refr != '0) begin
        refr_nxt = refr - 1'b1;
        pot_nxt  = RESET_VALUE;
        spk_nxt  = 1'b0;
      end else if (fire) begin
        spk_nxt  = 1'b1;
        pot_nxt  = RESET_VALUE;
        refr_nxt = RW'(REFRACT);
        cnt_nxt  = (cnt == '1) ? cnt : cnt + 1'b1;
      end else begin
        spk_nxt  = 1'b0;
        pot_nxt  = sat;
      end
    end

    // NOTE: per-neuron state is a few flops, not a RAM, so it is reset like
    // any other register and clear can wipe it in a single cycle.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pot  <= '0;
        refr <= '0;
        cnt  <= '0;
        spk  <= 1'b0;
      end else if (bus.clear) begin
        pot  <= '0;
        refr <= '0;
        cnt  <= '0;
        spk  <= 1'b0;
      end else if (bus.step) begin
        pot  <= pot_nxt;
        refr <= refr_nxt;
        cnt  <= cnt_nxt;
        spk  <= spk_nxt;
      end
    end

    assign bus.spike_out[i]                   = spk;
    assign bus.spike_count[i*CNT_W +: CNT_W]  = cnt;
  end

endmodule
